chess_move_executor: RTL and testbench
======================================

Name: chess_move_executor

Overview:
- Owns the 8x8 board register and executes player moves selected by two clicks: a source click, then a destination click.
- Feeds the selected figure, its position and the whole board to the combinational move generator, then samples the returned 64-bit possible-moves mask.
- Validates the destination against that mask, commits the move, handles captures, toggles the turn and flags game over.
- Sits between the mouse/board-coordinate front end and the move generator; drives the board drawing logic.

Parameters:
- MASK_LATENCY, 1, cycles from driving sel_figure/sel_pos until possible_moves is sampled (1..7).

Ports:
- clk  input  1  system clock
- rst_n  input  1  synchronous reset, active low
- click_valid  input  1  one-cycle strobe: click_pos is valid
- click_pos  input  6  clicked square; [2:0] col, [5:3] row
- possible_moves  input  64  mask from the move generator; bit row*8+col
- sel_figure  output  4  code of the selected figure to the move generator; 0 when nothing is selected
- sel_pos  output  6  position of the selected figure
- board_flat  output  256  board contents; square p occupies bits [p*4 +: 4]
- turn  output  1  side to move: 0 white, 1 black
- sel_valid  output  1  a figure is selected and its mask has been captured
- move_mask  output  64  captured mask, for highlighting; 0 when sel_valid=0
- move_done  output  1  one-cycle pulse when a move commits
- move_err  output  1  one-cycle pulse when a destination is rejected
- captured_code  output  4  code of the last captured figure; 0 if the last move was not a capture
- game_over  output  1  sticky; set when a king is captured

Behaviour:
- Figure codes:
  - 0 = empty.
  - White: 1 pawn, 2 bishop, 3 knight, 4 rook, 5 queen, 6 king.
  - Black: 7 pawn, 8 bishop, 9 knight, 10 rook, 11 queen, 12 king.
  - Colour of code c: white if 1..6, black if 7..12.
- Reset (rst_n=0 at a rising clk edge), initial board:
  - Row 0: 4,3,2,5,6,2,3,4. Row 1: all 1.
  - Rows 2..5: 0.
  - Row 6: all 7. Row 7: 10,9,8,11,12,8,9,10.
- Reset values of all other outputs: turn=0; sel_figure=0; sel_pos=0; sel_valid=0; move_mask=0; move_done=0; move_err=0; captured_code=0; game_over=0; FSM in IDLE.
- Reset mid-operation discards any selection and restores the initial board.
- FSM states: IDLE, MASK, ARMED, COMMIT.
- IDLE:
  - Triggered by click_valid with a square holding a figure of the side to move.
  - Latch sel_pos=click_pos and sel_figure=board code, load the wait counter with MASK_LATENCY, go to MASK.
  - Clicks on empty or opponent squares are ignored: no move_err.
- MASK:
  - Decrement the counter each cycle; clicks are ignored.
  - When the counter reaches 0, register move_mask=possible_moves, set sel_valid=1, go to ARMED.
  - With MASK_LATENCY=1, sel_valid rises 2 cycles after the source click.
- ARMED, on click_valid=d:
  - d == sel_pos: deselect. Clear sel_figure, sel_valid and move_mask; go to IDLE; no pulse.
  - Square d holds a figure of the side to move: reselect. Same actions as IDLE with the new square; go to MASK.
  - Otherwise, if move_mask[d]=1: latch d as the destination, go to COMMIT.
  - Otherwise: move_err=1 for one cycle; clear the selection; go to IDLE.
- COMMIT, one cycle:
  - board[d]=sel_figure (subject to promotion); board[sel_pos]=0.
  - captured_code = old board[d].
  - game_over is set if old board[d] is 6 or 12.
  - move_done=1; turn toggles.
  - Clear sel_figure, sel_valid and move_mask; go to IDLE.
  - Clicks arriving in the COMMIT cycle are dropped.
- When game_over=1: the FSM stays in IDLE and all clicks are ignored until reset.
- move_done and move_err are never asserted in the same cycle. Each is high for exactly one cycle.
- All outputs are registered. board_flat reflects a commit on the cycle after the COMMIT edge.

Optional Feature:
- Macro: PAWN_PROMOTION_EN.
- Defined: in COMMIT, a white pawn (1) landing on row 7 is written as 5; a black pawn (7) landing on row 0 is written as 11.
- Not defined: the pawn code is written unchanged; no promotion logic is synthesized.

Test Plan:
- Reset check: assert rst_n=0 for 2 cycles, then release -> board_flat[4*4 +: 4]=6, [60*4 +: 4]=12, [12*4 +: 4]=1, [28*4 +: 4]=0; turn=0; all pulses 0.
- Legal pawn move: click 12; model drives bit 28 in the mask; click 28 -> sel_figure=1 two cycles after the first click; move_done pulse; square 28=1, square 12=0; turn=1; captured_code=0.
- Illegal destination and wrong-side click: with turn=0, click 52 -> ignored. Click 12 with a mask lacking bit 36, then click 36 -> move_err pulse; board unchanged; sel_valid=0.
- Reselect and deselect: click 1 (knight), then click 12 (own pawn) -> sel_pos=12, sel_figure=1. Click 12 again -> sel_valid=0; no pulses.
- King capture: preload a position with a white queen at 20 and the black king at 60, mask bit 60 set; queen 20->60 -> captured_code=12; game_over=1; a subsequent click is ignored.
- Promotion (PAWN_PROMOTION_EN defined): white pawn 54->62 with mask bit 62 set -> square 62=5. Without the macro -> square 62=1.

Source files
------------

// File: rtl/chess_move_executor.sv
// -----------------------------------------------------------------------------
// chess_move_executor
//
// Owns the 8x8 board and executes moves chosen by two clicks: a source click
// that selects a figure of the side to move, then a destination click. The
// selected figure and its square are presented to an external combinational
// move generator. Its 64-bit possible-moves mask is sampled MASK_LATENCY+1
// edges after the selection. A destination inside that mask commits the move,
// records any capture, toggles the turn and flags game over when a king falls.
//
// Optional feature: define PAWN_PROMOTION_EN to promote a pawn that reaches the
// last rank to a queen of its colour (white 1 -> 5 on row 7, black 7 -> 11 on
// row 0). Without the macro the pawn code is written unchanged.
//
// Parameters
//   MASK_LATENCY   cycles from driving sel_figure/sel_pos to sampling the mask (1..7)
//
// Ports
//   clk             system clock
//   rst_n           synchronous reset, active low
//   click_valid     one-cycle strobe qualifying click_pos
//   click_pos       clicked square, [2:0] column, [5:3] row
//   possible_moves  mask from the move generator, bit row*8+col
//   sel_figure      selected figure code (0 when nothing is selected)
//   sel_pos         square of the selected figure
//   board_flat      board contents, square p at bits [p*4 +: 4]
//   turn            side to move, 0 white / 1 black
//   sel_valid       selection made and its mask captured
//   move_mask       captured mask (0 when sel_valid=0)
//   move_done       one-cycle pulse when a move commits
//   move_err        one-cycle pulse when a destination is rejected
//   captured_code   figure removed by the last committed move (0 if none)
//   game_over       sticky, set when a king is captured
// -----------------------------------------------------------------------------
module chess_move_executor #(
  parameter int MASK_LATENCY = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         click_valid,
  input  logic [5:0]   click_pos,
  input  logic [63:0]  possible_moves,
  output logic [3:0]   sel_figure,
  output logic [5:0]   sel_pos,
  output logic [255:0] board_flat,
  output logic         turn,
  output logic         sel_valid,
  output logic [63:0]  move_mask,
  output logic         move_done,
  output logic         move_err,
  output logic [3:0]   captured_code,
  output logic         game_over
);

  // Rows listed top (row 7) to bottom (row 0); square 0 is the low nibble.
  localparam logic [255:0] INIT_BOARD = {32'hA98CB89A, 32'h77777777, 128'h0,
                                         32'h11111111, 32'h43265234};
  localparam logic [2:0]   LAT        = 3'(MASK_LATENCY);

  typedef enum logic [1:0] {S_IDLE, S_MASK, S_ARMED, S_COMMIT} state_t;

  state_t         r_state, w_next;
  logic [2:0]     r_cnt;
  logic [255:0]   r_board;
  logic [5:0]     r_sel_pos, r_dst;
  logic [3:0]     r_sel_figure, r_captured;
  logic [63:0]    r_move_mask;
  logic           r_sel_valid, r_turn, r_move_done, r_move_err, r_game_over;

  logic [3:0]     w_click_code, w_dst_code, w_put_code;
  logic           w_click_own, w_mask_done;
  logic           w_load, w_capture, w_arm_dst, w_commit, w_reject, w_clear;

  function automatic logic owned_by(input logic [3:0] code, input logic side);
    return side ? (code >= 4'd7 && code <= 4'd12) : (code >= 4'd1 && code <= 4'd6);
  endfunction

  assign w_click_code = r_board[{click_pos, 2'b00} +: 4];
  assign w_dst_code   = r_board[{r_dst, 2'b00} +: 4];
  assign w_click_own  = owned_by(w_click_code, r_turn);
  assign w_mask_done  = (r_state == S_MASK) && (r_cnt == 3'd0);

`ifdef PAWN_PROMOTION_EN
  always_comb begin
    w_put_code = r_sel_figure;
    if (r_sel_figure == 4'd1 && r_dst[5:3] == 3'd7) w_put_code = 4'd5;
    if (r_sel_figure == 4'd7 && r_dst[5:3] == 3'd0) w_put_code = 4'd11;
  end
`else
  assign w_put_code = r_sel_figure;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (click_valid && !r_game_over && w_click_own) w_next = S_MASK;
      S_MASK:   if (w_mask_done) w_next = S_ARMED;
      S_ARMED:
        if (click_valid) begin
          if (click_pos == r_sel_pos)        w_next = S_IDLE;
          else if (w_click_own)              w_next = S_MASK;
          else if (r_move_mask[click_pos])   w_next = S_COMMIT;
          else                               w_next = S_IDLE;
        end
      S_COMMIT: w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // Per-state actions driving the datapath registers
  always_comb begin
    w_load    = 1'b0;
    w_capture = 1'b0;
    w_arm_dst = 1'b0;
    w_commit  = 1'b0;
    w_reject  = 1'b0;
    w_clear   = 1'b0;
    case (r_state)
      S_IDLE:   w_load = click_valid && !r_game_over && w_click_own;
      S_MASK:   w_capture = w_mask_done;
      S_ARMED:
        if (click_valid) begin
          if (click_pos == r_sel_pos)        w_clear = 1'b1;
          else if (w_click_own)              w_load = 1'b1;
          else if (r_move_mask[click_pos])   w_arm_dst = 1'b1;
          else begin
            w_reject = 1'b1;
            w_clear  = 1'b1;
          end
        end
      S_COMMIT: begin
        w_commit = 1'b1;
        w_clear  = 1'b1;
      end
      default: ;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: the board is game state, not a RAM, so it is reset to the opening position.
      r_board      <= INIT_BOARD;
      r_cnt        <= 3'd0;
      r_sel_pos    <= 6'd0;
      r_dst        <= 6'd0;
      r_sel_figure <= 4'd0;
      r_sel_valid  <= 1'b0;
      r_move_mask  <= 64'd0;
      r_turn       <= 1'b0;
      r_move_done  <= 1'b0;
      r_move_err   <= 1'b0;
      r_captured   <= 4'd0;
      r_game_over  <= 1'b0;
    end else begin
      r_move_done <= w_commit;
      r_move_err  <= w_reject;

      // A new selection (first pick or reselect) restarts the mask wait.
      if (w_load) begin
        r_sel_pos    <= click_pos;
        r_sel_figure <= w_click_code;
        r_cnt        <= LAT;
        r_sel_valid  <= 1'b0;
        r_move_mask  <= 64'd0;
      end else if (r_state == S_MASK && r_cnt != 3'd0) begin
        r_cnt <= r_cnt - 3'd1;
      end

      if (w_capture) begin
        r_move_mask <= possible_moves;
        r_sel_valid <= 1'b1;
      end

      if (w_arm_dst) r_dst <= click_pos;

      if (w_commit) begin
        r_board[{r_dst, 2'b00} +: 4]     <= w_put_code;
        r_board[{r_sel_pos, 2'b00} +: 4] <= 4'd0;
        r_captured                       <= w_dst_code;
        r_turn                           <= ~r_turn;
        if (w_dst_code == 4'd6 || w_dst_code == 4'd12) r_game_over <= 1'b1;
      end

      if (w_clear) begin
        r_sel_figure <= 4'd0;
        r_sel_valid  <= 1'b0;
        r_move_mask  <= 64'd0;
      end
    end
  end

  assign sel_figure    = r_sel_figure;
  assign sel_pos       = r_sel_pos;
  assign board_flat    = r_board;
  assign turn          = r_turn;
  assign sel_valid     = r_sel_valid;
  assign move_mask     = r_move_mask;
  assign move_done     = r_move_done;
  assign move_err      = r_move_err;
  assign captured_code = r_captured;
  assign game_over     = r_game_over;

endmodule

// File: tb/tb_chess_move_executor.sv
// -----------------------------------------------------------------------------
// tb_chess_move_executor
//
// Self-checking bench for chess_move_executor. A game-level model (board as an
// int array, side to move, game-over flag, current selection) predicts every
// observable result of each click. Directed scenarios cover reset, a legal
// pawn move, ignored clicks, rejection, reselect/deselect, a king capture and
// pawn promotion (honouring PAWN_PROMOTION_EN), followed by random games.
// -----------------------------------------------------------------------------
module tb_chess_move_executor;

  localparam int ML = 1;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         click_valid;
  logic [5:0]   click_pos;
  logic [63:0]  possible_moves;
  logic [3:0]   sel_figure;
  logic [5:0]   sel_pos;
  logic [255:0] board_flat;
  logic         turn;
  logic         sel_valid;
  logic [63:0]  move_mask;
  logic         move_done;
  logic         move_err;
  logic [3:0]   captured_code;
  logic         game_over;

  always #5 clk = ~clk;

  chess_move_executor #(.MASK_LATENCY(ML)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .click_valid    (click_valid),
    .click_pos      (click_pos),
    .possible_moves (possible_moves),
    .sel_figure     (sel_figure),
    .sel_pos        (sel_pos),
    .board_flat     (board_flat),
    .turn           (turn),
    .sel_valid      (sel_valid),
    .move_mask      (move_mask),
    .move_done      (move_done),
    .move_err       (move_err),
    .captured_code  (captured_code),
    .game_over      (game_over)
  );

  int checks = 0;
  int errors = 0;

  // Game-level reference model
  int          m_board[64];
  bit          m_turn, m_over, m_armed;
  int          m_captured, m_src;
  logic [63:0] m_mask;
  int          g_drop = -1;
  int          back_white[8] = '{4, 3, 2, 5, 6, 2, 3, 4};
  int          back_black[8] = '{10, 9, 8, 11, 12, 8, 9, 10};

  int          s, d, exp_promo;
  logic [63:0] rmask;
  int          own_sq[$];

  function automatic bit own(input int code, input bit side);
    return side ? (code >= 7 && code <= 12) : (code >= 1 && code <= 6);
  endfunction

  function automatic int promote(input int code, input int dst);
`ifdef PAWN_PROMOTION_EN
    if (code == 1 && dst / 8 == 7) return 5;
    if (code == 7 && dst / 8 == 0) return 11;
`endif
    return code;
  endfunction

  function automatic logic [255:0] model_flat();
    logic [255:0] v = '0;
    for (int p = 0; p < 64; p++) v[p*4 +: 4] = 4'(m_board[p]);
    return v;
  endfunction

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < 8; c++) begin
      m_board[c]      = back_white[c];
      m_board[8 + c]  = 1;
      m_board[48 + c] = 7;
      m_board[56 + c] = back_black[c];
      for (int r = 2; r < 6; r++) m_board[r*8 + c] = 0;
    end
    m_turn = 0; m_over = 0; m_armed = 0; m_captured = 0; m_src = 0; m_mask = '0;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    click_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic click(input int sq);
    click_pos   = 6'(sq);
    click_valid = 1'b1;
    @(posedge clk);
    #1;
    click_valid = 1'b0;
  endtask

  task automatic check_state(input string tag);
    check({tag, "_board"}, board_flat, model_flat());
    check({tag, "_turn"}, turn, m_turn);
    check({tag, "_over"}, game_over, m_over);
    check({tag, "_capt"}, captured_code, m_captured);
  endtask

  // Wait (bounded) for sel_valid; exp_n >= 0 also checks the edge count.
  task automatic wait_armed(input int exp_n);
    int n = 0;
    while (sel_valid !== 1'b1 && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (exp_n >= 0) check("mask_latency", n, exp_n);
    check("armed", sel_valid, 1'b1);
  endtask

  task automatic src_click(input int sq, input logic [63:0] mask);
    bit take;
    take = !m_over && own(m_board[sq], m_turn);
    possible_moves = mask;
    click(sq);
    check("src_no_done", move_done, 1'b0);
    check("src_no_err", move_err, 1'b0);
    if (take) begin
      check("src_fig", sel_figure, m_board[sq]);
      check("src_pos", sel_pos, sq);
      check("src_valid_low", sel_valid, 1'b0);
      wait_armed(ML + 1);
      check("src_mask", move_mask, mask);
      m_armed = 1; m_src = sq; m_mask = mask;
    end else begin
      check("ign_fig", sel_figure, 4'd0);
      check("ign_valid", sel_valid, 1'b0);
      check("ign_mask", move_mask, 64'd0);
      m_armed = 0;
    end
  endtask

  task automatic armed_click(input int sq, input logic [63:0] newmask);
    bit reselect;
    int cap;
    reselect = own(m_board[sq], m_turn);
    possible_moves = newmask;
    click(sq);
    if (sq == m_src) begin
      check("desel_valid", sel_valid, 1'b0);
      check("desel_fig", sel_figure, 4'd0);
      check("desel_mask", move_mask, 64'd0);
      check("desel_done", move_done, 1'b0);
      check("desel_err", move_err, 1'b0);
      m_armed = 0;
    end else if (reselect) begin
      check("resel_pos", sel_pos, sq);
      check("resel_fig", sel_figure, m_board[sq]);
      check("resel_valid", sel_valid, 1'b0);
      check("resel_mask0", move_mask, 64'd0);
      check("resel_pulse", {move_done, move_err}, 2'b00);
      wait_armed(ML + 1);
      check("resel_mask", move_mask, newmask);
      m_src = sq; m_mask = newmask;
    end else if (m_mask[sq]) begin
      check("commit_wait_done", move_done, 1'b0);
      check("commit_wait_valid", sel_valid, 1'b1);
      if (g_drop >= 0) begin
        click_pos   = 6'(g_drop);
        click_valid = 1'b1;
      end
      @(posedge clk);
      #1;
      click_valid = 1'b0;
      cap = m_board[sq];
      m_board[sq]    = promote(m_board[m_src], sq);
      m_board[m_src] = 0;
      m_captured     = cap;
      if (cap == 6 || cap == 12) m_over = 1;
      m_turn = !m_turn;
      check("commit_done", move_done, 1'b1);
      check("commit_err", move_err, 1'b0);
      check("commit_valid", sel_valid, 1'b0);
      check("commit_fig", sel_figure, 4'd0);
      check("commit_mask", move_mask, 64'd0);
      check_state("commit");
      @(posedge clk);
      #1;
      check("done_pulse_end", move_done, 1'b0);
      check("post_commit_fig", sel_figure, 4'd0);
      check("post_commit_valid", sel_valid, 1'b0);
      m_armed = 0;
    end else begin
      check("rej_err", move_err, 1'b1);
      check("rej_done", move_done, 1'b0);
      check("rej_valid", sel_valid, 1'b0);
      check("rej_fig", sel_figure, 4'd0);
      check("rej_mask", move_mask, 64'd0);
      check_state("rej");
      @(posedge clk);
      #1;
      check("err_pulse_end", move_err, 1'b0);
      m_armed = 0;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired before the summary line");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    click_valid = 1'b0;
    click_pos = '0;
    possible_moves = '0;

    // Reset state
    apply_reset();
    check("rst_sq4", board_flat[4*4 +: 4], 4'd6);
    check("rst_sq60", board_flat[60*4 +: 4], 4'd12);
    check("rst_sq12", board_flat[12*4 +: 4], 4'd1);
    check("rst_sq28", board_flat[28*4 +: 4], 4'd0);
    check_state("rst");
    check("rst_pulses", {move_done, move_err}, 2'b00);
    check("rst_sel", {sel_valid, sel_figure, sel_pos}, 11'd0);
    check("rst_mask", move_mask, 64'd0);

    // Wrong side ignored; destination outside the mask rejected
    src_click(52, 64'hFFFF_FFFF_FFFF_FFFF);
    src_click(12, 64'd1 << 28);
    armed_click(36, '0);

    // Clicks during MASK ignored; reselect own pawn; deselect
    possible_moves = (64'd1 << 16) | (64'd1 << 18);
    click(1);
    check("mask_sel_fig", sel_figure, 4'd3);
    click(12);
    check("mask_ignore_pos", sel_pos, 6'd1);
    check("mask_ignore_fig", sel_figure, 4'd3);
    wait_armed(ML);
    m_armed = 1; m_src = 1; m_mask = possible_moves;
    armed_click(12, 64'd1 << 28);
    check("resel_pos12", sel_pos, 6'd12);
    check("resel_fig1", sel_figure, 4'd1);
    armed_click(12, '0);

    // Legal pawn move 12->28 with a click dropped during COMMIT
    src_click(12, 64'd1 << 28);
    g_drop = 13;
    armed_click(28, '0);
    g_drop = -1;
    check("pawn_sq28", board_flat[28*4 +: 4], 4'd1);
    check("pawn_sq12", board_flat[12*4 +: 4], 4'd0);
    check("pawn_turn", turn, 1'b1);
    check("pawn_capt", captured_code, 4'd0);

    // Reach white queen on 20, then capture the black king on 60
    src_click(52, 64'd1 << 44);  armed_click(44, '0);
    src_click(3,  64'd1 << 20);  armed_click(20, '0);
    src_click(51, 64'd1 << 43);  armed_click(43, '0);
    src_click(20, 64'd1 << 60);  armed_click(60, '0);
    check("king_capt", captured_code, 4'd12);
    check("king_over", game_over, 1'b1);
    src_click(43, 64'hFFFF_FFFF_FFFF_FFFF);
    repeat (3) @(posedge clk);
    #1;
    check("over_idle", sel_valid, 1'b0);
    check("over_sticky", game_over, 1'b1);

    // Reset mid-selection
    apply_reset();
    src_click(11, 64'd1 << 27);
    apply_reset();
    check("midrst_valid", sel_valid, 1'b0);
    check("midrst_fig", sel_figure, 4'd0);
    check_state("midrst");

    // Promotion: white pawn 14 -> 54 -> 62
    src_click(14, 64'd1 << 54);  armed_click(54, '0);
    src_click(48, 64'd1 << 40);  armed_click(40, '0);
    src_click(54, 64'd1 << 62);  armed_click(62, '0);
`ifdef PAWN_PROMOTION_EN
    exp_promo = 5;
`else
    exp_promo = 1;
`endif
    check("promo_sq62", board_flat[62*4 +: 4], 4'(exp_promo));
    check("promo_capt", captured_code, 4'd9);

    // Random games
    apply_reset();
    for (int it = 0; it < 80; it++) begin
      if (m_over) apply_reset();
      own_sq.delete();
      for (int p = 0; p < 64; p++) if (own(m_board[p], m_turn)) own_sq.push_back(p);
      if ($urandom_range(0, 4) != 0) s = own_sq[$urandom_range(0, own_sq.size() - 1)];
      else                           s = $urandom_range(0, 63);
      rmask = {$urandom, $urandom};
      src_click(s, rmask);
      for (int k = 0; k < 3 && m_armed; k++) begin
        if ($urandom_range(0, 9) == 0) d = m_src;
        else                           d = $urandom_range(0, 63);
        armed_click(d, {$urandom, $urandom});
      end
      if (m_armed) armed_click(m_src, '0);
    end
    check_state("rand_end");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
